// File: rtl/ioctl_upload_reader.sv
// Upload read-back engine: serves HPS byte reads from a shared core RAM port,
// stalling the HPS with ioctl_wait until the requested byte is valid.
module ioctl_upload_reader #(
  parameter int         ADDR_W   = 12,
  parameter int         MEM_SIZE = 4096,
  parameter int         RD_LAT   = 2,
  parameter logic [7:0] FILL     = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [15:0]       byte_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_LAT   = 3'd2,
    S_FILL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_upload_d;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic [2:0]          w_cnt_dec;
  logic                w_rise;
  logic                w_fall;
  logic                w_accept;
  logic                w_in_range;
  logic [7:0]          w_din_nxt;
  logic                w_wait_nxt;
  logic                w_req_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_done_nxt;
  logic                w_ovr_nxt;
  logic [15:0]         w_bc_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_rise     = ioctl_upload & ~r_upload_d;
  assign w_fall     = ~ioctl_upload & r_upload_d;
  assign w_accept   = (r_state == S_IDLE) & ioctl_rd & ioctl_upload;
  assign w_in_range = ({7'd0, ioctl_addr} < 32'(MEM_SIZE));
  assign w_cnt_dec  = (r_cnt > 3'd1) ? r_cnt - 3'd1 : r_cnt;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a falling upload preempts the normal flow
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_in_range ? S_ARB : S_FILL;
        else          w_state_nxt = S_IDLE;
      end
      S_ARB: begin
        if (w_fall)       w_state_nxt = S_IDLE;
        else if (mem_gnt) w_state_nxt = S_LAT;
        else              w_state_nxt = S_ARB;
      end
      S_LAT: begin
        if (w_fall)              w_state_nxt = S_DRAIN;
        else if (r_cnt == 3'd1)  w_state_nxt = S_IDLE;
        else                     w_state_nxt = S_LAT;
      end
      S_FILL:  w_state_nxt = S_IDLE;
      S_DRAIN: begin
        if (r_cnt == 3'd1) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; session-start clears apply before a new request
  always_comb begin
    w_din_nxt  = ioctl_din;
    w_wait_nxt = ioctl_wait;
    w_req_nxt  = mem_req;
    w_addr_nxt = mem_addr;
    w_done_nxt = 1'b0;
    w_ovr_nxt  = overrun;
    w_bc_nxt   = byte_count;
    w_cnt_nxt  = r_cnt;
    if (w_rise) begin
      w_ovr_nxt = 1'b0;
      w_bc_nxt  = 16'd0;
    end else begin
      w_ovr_nxt = overrun;
    end
    if (ioctl_rd && (r_state != S_IDLE)) w_ovr_nxt = 1'b1;
    else                                 w_ovr_nxt = w_ovr_nxt;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_done_nxt = 1'b1;
        end else if (w_accept) begin
          w_wait_nxt = 1'b1;
          if (w_in_range) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = ioctl_addr[ADDR_W-1:0];
          end else begin
            w_req_nxt  = 1'b0;
          end
        end else begin
          w_wait_nxt = ioctl_wait;
        end
      end
      S_ARB: begin
        if (w_fall) begin
          w_req_nxt  = 1'b0;
          w_wait_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else if (mem_gnt) begin
          w_req_nxt = 1'b0;
          w_cnt_nxt = 3'(RD_LAT);
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_LAT: begin
        w_cnt_nxt = w_cnt_dec;
        if (!w_fall && (r_cnt == 3'd1)) begin
          w_din_nxt  = mem_q;
          w_wait_nxt = 1'b0;
          w_bc_nxt   = sat_inc(byte_count);
        end else begin
          w_wait_nxt = ioctl_wait;
        end
      end
      S_FILL: begin
        w_wait_nxt = 1'b0;
        if (w_fall) begin
          w_done_nxt = 1'b1;
        end else begin
          w_din_nxt = FILL;
          w_bc_nxt  = sat_inc(byte_count);
        end
      end
      S_DRAIN: begin
        w_cnt_nxt = w_cnt_dec;
        if (r_cnt == 3'd1) begin
          w_wait_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else begin
          w_wait_nxt = ioctl_wait;
        end
      end
      default: begin
        w_req_nxt  = 1'b0;
        w_wait_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_upload_d <= 1'b0;
      r_cnt      <= 3'd0;
      ioctl_din  <= 8'd0;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      byte_count <= 16'd0;
    end else begin
      r_upload_d <= ioctl_upload;
      r_cnt      <= w_cnt_nxt;
      ioctl_din  <= w_din_nxt;
      ioctl_wait <= w_wait_nxt;
      mem_req    <= w_req_nxt;
      mem_addr   <= w_addr_nxt;
      busy       <= (w_state_nxt != S_IDLE);
      done       <= w_done_nxt;
      overrun    <= w_ovr_nxt;
      byte_count <= w_bc_nxt;
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed + randomized bench for ioctl_upload_reader against a byte-level
// reference model (RAM contents, FILL rule, latency budget, session counters).
module tb_ioctl_upload_reader;

  localparam int RD_LAT   = 2;
  localparam int MEM_SIZE = 4096;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic        mem_gnt = 1'b0;
  logic [7:0]  mem_q = 8'h00;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] byte_count;

  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] exp_count = 16'd0;
  logic [7:0]  exp_din = 8'd0;
  logic [7:0]  ram [0:4095];
  int          k = 0;
  logic [11:0] g_addr = 12'd0;

  ioctl_upload_reader #(
    .ADDR_W(12), .MEM_SIZE(MEM_SIZE), .RD_LAT(RD_LAT), .FILL(8'hFF)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_q(mem_q), .busy(busy), .done(done),
    .overrun(overrun), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM responder: data for the granted address is on mem_q RD_LAT cycles after the grant, junk otherwise
  always begin
    @(posedge clk_sys);
    if (mem_req && mem_gnt) begin
      k = 1;
      g_addr = mem_addr;
    end else if (k != 0) begin
      k = (k >= RD_LAT) ? 0 : k + 1;
    end
    #1;
    mem_q = (k == RD_LAT) ? ram[g_addr] : 8'($urandom);
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read: grant withheld for 'hold' arbitration cycles; checks timing, data and counters
  task automatic read_txn(input logic [24:0] a, input int hold);
    int  wait_cycles;
    int  req_cycles;
    int  guard;
    bit  addr_ok;
    bit  in_range;
    logic [11:0] a12;
    a12 = a[11:0];
    in_range = (a < MEM_SIZE);
    exp_din = in_range ? ram[a12] : 8'hFF;
    exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    wait_cycles = 0;
    req_cycles = 0;
    addr_ok = 1'b1;
    guard = 0;
    while (ioctl_wait && guard < 100) begin
      mem_gnt = (req_cycles >= hold);
      if (mem_req) begin
        if (mem_addr !== a12) addr_ok = 1'b0;
        req_cycles++;
      end
      wait_cycles++;
      step();
      guard++;
    end
    mem_gnt = 1'b0;
    chk("wait_width", 64'(wait_cycles), in_range ? 64'(hold + RD_LAT + 1) : 64'd1);
    chk("req_width", 64'(req_cycles), in_range ? 64'(hold + 1) : 64'd0);
    chk("addr_stable", 64'(addr_ok), 64'd1);
    chk("din", 64'(ioctl_din), 64'(exp_din));
    chk("byte_count", 64'(byte_count), 64'(exp_count));
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int done_seen;
    int done_at;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h010] = 8'h5A;
    ram[12'hFFF] = 8'hC3;

    #1;
    chk("reset_outputs", {ioctl_din, ioctl_wait, mem_req, mem_addr, busy, done, overrun, byte_count}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    ioctl_upload = 1'b1;
    step();
    read_txn(25'h010, 0);
    read_txn(25'hFFF, 5);
    read_txn(25'h1000, 0);

    // Back-to-back strobe: second request is dropped and flagged
    exp_din = ram[12'h020];
    exp_count = exp_count + 16'd1;
    ioctl_addr = 25'h020;
    ioctl_rd = 1'b1;
    mem_gnt = 1'b1;
    step();
    ioctl_addr = 25'h021;
    step();
    ioctl_rd = 1'b0;
    for (int i = 0; i < 8; i++) step();
    mem_gnt = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_din", 64'(ioctl_din), 64'(exp_din));
    chk("ovr_count", 64'(byte_count), 64'(exp_count));
    chk("ovr_idle", 64'({busy, ioctl_wait, mem_req}), 64'd0);

    for (int i = 0; i < 24; i++) begin
      read_txn(25'($urandom_range(0, 6143)), int'($urandom_range(0, 3)));
    end
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // Upload falls while idle: single done pulse
    ioctl_upload = 1'b0;
    step();
    chk("done_idle", 64'(done), 64'd1);
    step();
    chk("done_once", 64'(done), 64'd0);

    // Strobe without an active session is ignored
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h030;
    step();
    ioctl_rd = 1'b0;
    step();
    chk("rd_no_upload", 64'({busy, ioctl_wait, mem_req}), 64'd0);

    // New session with a same-cycle request: clears first, then serves the byte
    ioctl_upload = 1'b1;
    exp_count = 16'd0;
    read_txn(25'h040, 1);
    chk("ovr_cleared", 64'(overrun), 64'd0);

    // Upload falls in arbitration
    ioctl_addr = 25'h050;
    ioctl_rd = 1'b1;
    mem_gnt = 1'b0;
    step();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    step();
    chk("arb_drop", 64'({mem_req, ioctl_wait, busy, done}), 64'b0001);
    chk("arb_din", 64'(ioctl_din), 64'(exp_din));
    step();
    chk("arb_done_once", 64'(done), 64'd0);

    // Upload falls in latency: drain, byte discarded, done after RD_LAT
    ioctl_upload = 1'b1;
    exp_count = 16'd0;
    step();
    ioctl_addr = 25'h060;
    ioctl_rd = 1'b1;
    mem_gnt = 1'b1;
    step();
    ioctl_rd = 1'b0;
    step();
    ioctl_upload = 1'b0;
    mem_gnt = 1'b0;
    done_seen = 0;
    done_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done) begin
        done_seen++;
        if (done_at < 0) done_at = i;
      end
    end
    chk("drain_done_cnt", 64'(done_seen), 64'd1);
    chk("drain_done_at", 64'(done_at), 64'(RD_LAT));
    chk("drain_din", 64'(ioctl_din), 64'(exp_din));
    chk("drain_count", 64'(byte_count), 64'(exp_count));
    chk("drain_idle", 64'({busy, ioctl_wait}), 64'd0);

    // Reset in the middle of a fetch
    ioctl_upload = 1'b1;
    step();
    ioctl_addr = 25'h070;
    ioctl_rd = 1'b1;
    mem_gnt = 1'b1;
    step();
    ioctl_rd = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("reset_async", {ioctl_din, ioctl_wait, mem_req, mem_addr, busy, done, overrun, byte_count}, 64'd0);
    step();
    reset_n = 1'b1;
    exp_count = 16'd0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_seen++;
    end
    chk("reset_no_done", 64'(done_seen), 64'd0);
    read_txn(25'h080, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
